pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Fetch-side controller that owns the program counter and sequences instruction fetch for the RISC-V core. It issues requests to instruction memory, buffers the returned word for decode, and chooses the next PC with fixed priority: trap, then redirect (branch/jump), then sequential +4. It replaces a free-running PC register with a stall-, halt- and redirect-aware sequencer.

## Interface
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset
- TRAP_VECTOR, 32'h0000_0100, target on trap_valid (and on misalign when enabled)
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- imem_req  out  1  fetch request, held until imem_ack
- imem_addr  out  32  fetch address, stable while imem_req=1
- imem_ack  in  1  memory response; imem_rdata valid same cycle
- imem_rdata  in  32  fetched instruction
- instr_valid  out  1  buffered instruction available to decode
- instr  out  32  buffered instruction
- instr_pc  out  32  PC of instr
- instr_ready  in  1  decode accepts instr when instr_valid=1
- redirect_valid  in  1  branch/jump taken, one-cycle pulse
- redirect_pc  in  32  redirect target
- trap_valid  in  1  exception/ecall, one-cycle pulse
- halt  in  1  level; stop fetching while high
- pc  out  32  current fetch PC
- misalign_trap  out  1  misaligned-redirect pulse (tied 0 when feature compiled out)

## Operation
- States: BOOT, REQ, HOLD, HALTED.
- BOOT: entered on reset. pc=RESET_VECTOR. Next cycle goes to HALTED if halt=1, else REQ.
- REQ: imem_req=1 and imem_addr=pc.
  - imem_ack with no pending redirect: capture imem_rdata into instr, pc into instr_pc, go HOLD.
  - Redirect or trap arriving in REQ: the request is not withdrawn. Load pc with the target and set a discard flag. On imem_ack, drop the data, clear the flag and re-enter REQ at the new pc.
  - Redirect arriving in the same cycle as imem_ack: the data is discarded and the redirect wins.
- HOLD: instr_valid=1.
  - Trap or redirect: instr_valid drops next cycle, pc takes the target, go REQ. This applies with or without instr_ready.
  - instr_ready=1 with no redirect: pc <= pc+4, go HALTED if halt=1, else REQ.
  - Otherwise: stay in HOLD; instr, instr_pc and pc stay stable.
- HALTED: imem_req=0 and instr_valid=0. A redirect or trap updates pc. Goes to REQ when halt=0.
- Priority: trap_valid > redirect_valid > sequential.
- Arithmetic: pc+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- Reset mid-handshake: at the reset edge all state returns to reset values, the outstanding request is abandoned and no discard flag survives.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_VECTOR, pc=RESET_VECTOR, instr_valid=0, instr=32'h0000_0013 (NOP), instr_pc=0, misalign_trap=0. The discard flag is 0.
- First imem_req: 1 cycle after the first edge with rst_n=1.
- imem_ack in the same cycle as imem_req: instr_valid=1 on the next cycle.
- Peak throughput: 1 instruction per 2 cycles (REQ, HOLD).
- Redirect in HOLD: imem_req=1 at the target on the next cycle.
- All outputs are registered, except imem_addr, which is pc.

## Configuration
- PC_MISALIGN_TRAP_EN defined:
  - A redirect_pc with bits [1:0]≠0 is not taken; pc is loaded with TRAP_VECTOR instead.
  - misalign_trap pulses 1 for one cycle, aligned with the pc update.
- PC_MISALIGN_TRAP_EN undefined:
  - redirect_pc[1:0] is forced to 2'b00.
  - misalign_trap is constant 0.

## Structure
- Package pc_seq_pkg:
  - state enum (BOOT, REQ, HOLD, HALTED)
  - NOP_INSTR = 32'h0000_0013
  - PC_STEP = 4
- Sub-module pc_next_sel: combinational priority mux. Inputs are trap, redirect (with the alignment check), sequential and hold; output is next pc.
- FSM, discard flag and instruction buffer stay in pc_sequencer.

## Test plan
- Reset release, imem_ack tied 1, instr_ready=1 -> imem_addr 0x0, 0x4, 0x8 on alternating cycles; instr_pc matches each.
- HOLD with instr_ready=0 for 5 cycles -> instr, instr_pc and pc stable; then ready -> next fetch at pc+4.
- imem_ack delayed 3 cycles, redirect_pc=0x200 pulsed in the 2nd wait cycle -> returned word is never valid; next imem_addr=0x200.
- trap_valid and redirect_valid (0x300) in the same HOLD cycle -> next imem_addr=0x100.
- halt=1 during HOLD, then released -> no imem_req while halted; resume at pc+4, or at the target if redirected while halted.
- PC_MISALIGN_TRAP_EN defined, redirect_pc=0x202 -> pc=0x100 and misalign_trap pulses once. Undefined -> pc=0x200 and misalign_trap=0.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch-side PC sequencer.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    StBoot,
    StReq,
    StHold,
    StHalted
  } state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch, decode-handoff and control-flow signals of the PC sequencer.
interface pc_sequencer_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        trap_valid;
  logic        halt;
  logic [31:0] pc;
  logic        misalign_trap;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, pc, misalign_trap,
    input  imem_ack, imem_rdata, instr_ready, redirect_valid, redirect_pc, trap_valid, halt
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, pc, misalign_trap,
    output imem_ack, imem_rdata, instr_ready, redirect_valid, redirect_pc, trap_valid, halt
  );

endinterface

// File: rtl/pc_next_sel.sv
// Next-PC priority mux: trap > redirect > sequential > hold.
// PC_MISALIGN_TRAP_EN turns misaligned redirect targets into a trap.
module pc_next_sel
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
  input  logic [31:0] pc_i,
  input  logic        trap_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        seq_i,
  output logic [31:0] next_pc_o,
  output logic        misalign_o
);

  logic [31:0] redir_pc;
  logic        redir_bad;

  always_comb begin
    redir_pc  = redirect_pc_i;
`ifdef PC_MISALIGN_TRAP_EN
    redir_bad = is_misaligned(redirect_pc_i);
`else
    // Without the trap feature, low bits are simply dropped.
    redir_pc[1:0] = 2'b00;
    redir_bad     = 1'b0;
`endif
  end

  always_comb begin
    next_pc_o  = pc_i;
    misalign_o = 1'b0;
    if (trap_i) begin
      next_pc_o = TRAP_VECTOR;
    end else if (redirect_i) begin
      if (redir_bad) begin
        next_pc_o  = TRAP_VECTOR;
        misalign_o = 1'b1;
      end else begin
        next_pc_o = redir_pc;
      end
    end else if (seq_i) begin
      next_pc_o = pc_i + PC_STEP;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch sequencer: owns the PC, issues imem requests and buffers one instruction for decode.
// Optional PC_MISALIGN_TRAP_EN (handled in pc_next_sel) traps misaligned redirects.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input logic            clk,
  input logic            rst_n,
  pc_sequencer_if.master bus
);

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] instr_pc_q;
  logic        imem_req_q;
  logic        instr_valid_q;
  logic        discard_q;
  logic        misalign_q;

  logic        flow_change;
  logic        flow_en;
  logic        seq_adv;
  logic [31:0] next_pc;
  logic        sel_misalign;

  always_comb begin
    flow_change = bus.trap_valid | bus.redirect_valid;
    // Control-flow inputs are ignored only in the boot cycle.
    flow_en     = (state_q != StBoot);
    seq_adv     = (state_q == StHold) & bus.instr_ready & ~flow_change;
  end

  pc_next_sel #(
    .TRAP_VECTOR (TRAP_VECTOR)
  ) u_pc_next_sel (
    .pc_i          (pc_q),
    .trap_i        (bus.trap_valid & flow_en),
    .redirect_i    (bus.redirect_valid & flow_en),
    .redirect_pc_i (bus.redirect_pc),
    .seq_i         (seq_adv),
    .next_pc_o     (next_pc),
    .misalign_o    (sel_misalign)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StBoot;
      pc_q          <= RESET_VECTOR;
      instr_q       <= NOP_INSTR;
      instr_pc_q    <= 32'h0000_0000;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      discard_q     <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      pc_q       <= next_pc;
      misalign_q <= sel_misalign;
      unique case (state_q)
        StBoot: begin
          if (bus.halt) begin
            state_q    <= StHalted;
            imem_req_q <= 1'b0;
          end else begin
            state_q    <= StReq;
            imem_req_q <= 1'b1;
          end
        end
        StReq: begin
          if (bus.imem_ack) begin
            discard_q <= 1'b0;
            // Stale or overtaken response: drop it and fetch again at the new pc.
            if (!(discard_q || flow_change)) begin
              instr_q       <= bus.imem_rdata;
              instr_pc_q    <= pc_q;
              instr_valid_q <= 1'b1;
              imem_req_q    <= 1'b0;
              state_q       <= StHold;
            end
          end else if (flow_change) begin
            discard_q <= 1'b1;
          end
        end
        StHold: begin
          if (flow_change) begin
            instr_valid_q <= 1'b0;
            imem_req_q    <= 1'b1;
            state_q       <= StReq;
          end else if (bus.instr_ready) begin
            instr_valid_q <= 1'b0;
            if (bus.halt) begin
              state_q <= StHalted;
            end else begin
              imem_req_q <= 1'b1;
              state_q    <= StReq;
            end
          end
        end
        StHalted: begin
          if (!bus.halt) begin
            imem_req_q <= 1'b1;
            state_q    <= StReq;
          end
        end
        default: begin
          state_q    <= StBoot;
          imem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req      = imem_req_q;
  assign bus.imem_addr     = pc_q;
  assign bus.pc            = pc_q;
  assign bus.instr_valid   = instr_valid_q;
  assign bus.instr         = instr_q;
  assign bus.instr_pc      = instr_pc_q;
  assign bus.misalign_trap = misalign_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scenarios plus a randomized run scored against a PC-stream reference model.
module tb_pc_sequencer;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [31:0] salt;

  pc_sequencer_if bus();

  pc_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time expired");
    $fatal(1);
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ salt;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.instr_ready = 1'b0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.trap_valid = 1'b0; bus.halt = 1'b0;
  endtask

  task automatic pulse(input logic redir, input logic [31:0] tgt, input logic trap);
    bus.redirect_valid = redir; bus.redirect_pc = tgt; bus.trap_valid = trap;
    tick();
    bus.redirect_valid = 1'b0; bus.trap_valid = 1'b0;
  endtask

  // Wait (bounded) for a request, then acknowledge it after lat idle cycles.
  task automatic serve(input int lat);
    int n = 0;
    while (bus.imem_req !== 1'b1 && n < 20) begin tick(); n++; end
    checks++;
    if (bus.imem_req !== 1'b1) begin
      errors++; $display("FAIL serve_timeout: imem_req=%b required 1", bus.imem_req);
    end else begin
      repeat (lat) tick();
      bus.imem_ack = 1'b1; bus.imem_rdata = mem_word(bus.imem_addr);
      tick();
      bus.imem_ack = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle_inputs();
    repeat (3) tick();
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", bus.imem_req); end
    checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", bus.imem_addr); end
    checks++; if (bus.pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", bus.pc); end
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.instr_valid); end
    checks++; if (bus.instr !== 32'h13) begin errors++; $display("FAIL reset_instr: got %h want 00000013", bus.instr); end
    checks++; if (bus.instr_pc !== 32'h0) begin errors++; $display("FAIL reset_instr_pc: got %h want 0", bus.instr_pc); end
    checks++; if (bus.misalign_trap !== 1'b0) begin errors++; $display("FAIL reset_mis: got %b want 0", bus.misalign_trap); end
    rst_n = 1'b1;
    tick();
    checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL first_req: got %b want 1", bus.imem_req); end
    checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL first_addr: got %h want 0", bus.imem_addr); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_req = 32'h0;
    logic [31:0] exp_ins = 32'h0;
    bus.imem_ack = 1'b1; bus.instr_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      bus.imem_rdata = mem_word(bus.imem_addr);
      checks++;
      if (bus.imem_req !== ((c % 2) == 0)) begin
        errors++; $display("FAIL seq_alternate: cycle %0d req=%b valid=%b", c, bus.imem_req, bus.instr_valid);
      end
      if (bus.imem_req) begin
        checks++; if (bus.imem_addr !== exp_req) begin errors++; $display("FAIL seq_addr: got %h want %h", bus.imem_addr, exp_req); end
        exp_req += 32'd4;
      end
      if (bus.instr_valid) begin
        checks++; if (bus.instr_pc !== exp_ins) begin errors++; $display("FAIL seq_instr_pc: got %h want %h", bus.instr_pc, exp_ins); end
        checks++; if (bus.instr !== mem_word(exp_ins)) begin errors++; $display("FAIL seq_instr: got %h want %h", bus.instr, mem_word(exp_ins)); end
        exp_ins += 32'd4;
      end
      tick();
    end
    bus.imem_ack = 1'b0; bus.instr_ready = 1'b0;
  endtask

  task automatic test_stall();
    serve(0);
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h20 || bus.pc !== 32'h20 || bus.instr !== mem_word(32'h20)) begin
        errors++; $display("FAIL stall_stable: valid=%b instr_pc=%h pc=%h instr=%h want 1/20/20/%h",
                           bus.instr_valid, bus.instr_pc, bus.pc, bus.instr, mem_word(32'h20));
      end
      tick();
    end
    bus.instr_ready = 1'b1; tick(); bus.instr_ready = 1'b0;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h24) begin
      errors++; $display("FAIL stall_resume: req=%b addr=%h want 1/00000024", bus.imem_req, bus.imem_addr); end
  endtask

  task automatic test_discard();
    tick();
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL discard_w1: valid=%b want 0", bus.instr_valid); end
    pulse(1'b1, 32'h200, 1'b0);
    tick();
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL discard_w3: valid=%b want 0", bus.instr_valid); end
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF; tick(); bus.imem_ack = 1'b0;
    checks++; if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h200) begin
      errors++; $display("FAIL discard_refetch: valid=%b req=%b addr=%h want 0/1/00000200", bus.instr_valid, bus.imem_req, bus.imem_addr); end
    serve(0);
    checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h200 || bus.instr !== mem_word(32'h200)) begin
      errors++; $display("FAIL discard_target: valid=%b instr_pc=%h instr=%h want 1/00000200/%h", bus.instr_valid, bus.instr_pc, bus.instr, mem_word(32'h200)); end
  endtask

  task automatic test_trap_priority();
    pulse(1'b1, 32'h300, 1'b1);
    checks++; if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) begin
      errors++; $display("FAIL trap_priority: valid=%b req=%b addr=%h want 0/1/00000100", bus.instr_valid, bus.imem_req, bus.imem_addr); end
  endtask

  task automatic test_halt();
    serve(0);
    bus.halt = 1'b1; bus.instr_ready = 1'b1; tick(); bus.instr_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      checks++; if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || bus.pc !== 32'h104) begin
        errors++; $display("FAIL halt_idle: req=%b valid=%b pc=%h want 0/0/00000104", bus.imem_req, bus.instr_valid, bus.pc); end
      tick();
    end
    bus.halt = 1'b0; tick();
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h104) begin
      errors++; $display("FAIL halt_resume: req=%b addr=%h want 1/00000104", bus.imem_req, bus.imem_addr); end
    serve(0);
    bus.halt = 1'b1; bus.instr_ready = 1'b1; tick(); bus.instr_ready = 1'b0;
    tick();
    pulse(1'b1, 32'h400, 1'b0);
    checks++; if (bus.imem_req !== 1'b0 || bus.pc !== 32'h400) begin
      errors++; $display("FAIL halt_redirect: req=%b pc=%h want 0/00000400", bus.imem_req, bus.pc); end
    bus.halt = 1'b0; tick();
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h400) begin
      errors++; $display("FAIL halt_redirect_resume: req=%b addr=%h want 1/00000400", bus.imem_req, bus.imem_addr); end
  endtask

  task automatic test_misalign();
    logic [31:0] exp_pc;
    logic        exp_mis;
`ifdef PC_MISALIGN_TRAP_EN
    exp_pc = 32'h100; exp_mis = 1'b1;
`else
    exp_pc = 32'h200; exp_mis = 1'b0;
`endif
    serve(0);
    pulse(1'b1, 32'h202, 1'b0);
    checks++; if (bus.pc !== exp_pc || bus.misalign_trap !== exp_mis) begin
      errors++; $display("FAIL misalign: pc=%h mis=%b want %h/%b", bus.pc, bus.misalign_trap, exp_pc, exp_mis); end
    tick();
    checks++; if (bus.misalign_trap !== 1'b0) begin errors++; $display("FAIL misalign_pulse: mis=%b want 0", bus.misalign_trap); end
  endtask

  task automatic test_wrap();
    serve(0);
    pulse(1'b1, 32'hFFFF_FFFC, 1'b0);
    serve(0);
    checks++; if (bus.instr_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_instr_pc: got %h want fffffffc", bus.instr_pc); end
    bus.instr_ready = 1'b1; tick(); bus.instr_ready = 1'b0;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      errors++; $display("FAIL wrap_addr: req=%b addr=%h want 1/00000000", bus.imem_req, bus.imem_addr); end
  endtask

  // Reference: the delivered stream is pc, pc+4, ... restarting at every trap/redirect target.
  task automatic test_random();
    logic [31:0] exp_pc = 32'h0;
    logic        exp_mis = 1'b0;
    logic [31:0] tgt;
    logic        trap, redir;
    int          lat = 0;
    int          delivered = 0;
    int          r;
    rst_n = 1'b0; idle_inputs(); tick(); tick();
    rst_n = 1'b1; tick();
    for (int c = 0; c < 3000; c++) begin
      checks++; if (bus.pc !== exp_pc) begin errors++; $display("FAIL rnd_pc: cycle %0d got %h want %h", c, bus.pc, exp_pc); end
      checks++; if (bus.misalign_trap !== exp_mis) begin errors++; $display("FAIL rnd_mis: cycle %0d got %b want %b", c, bus.misalign_trap, exp_mis); end
      checks++; if (bus.imem_req === 1'b1 && bus.instr_valid === 1'b1) begin errors++; $display("FAIL rnd_exclusive: cycle %0d req and valid both 1", c); end
      if (bus.imem_req) begin
        checks++; if (bus.imem_addr !== exp_pc) begin errors++; $display("FAIL rnd_addr: cycle %0d got %h want %h", c, bus.imem_addr, exp_pc); end
      end
      if (bus.instr_valid) begin
        checks++; if (bus.instr_pc !== exp_pc || bus.instr !== mem_word(exp_pc)) begin
          errors++; $display("FAIL rnd_instr: cycle %0d pc=%h instr=%h want %h/%h", c, bus.instr_pc, bus.instr, exp_pc, mem_word(exp_pc)); end
      end
      r     = $urandom_range(0, 99);
      trap  = (r < 2);
      redir = (r >= 2 && r < 8);
      tgt   = $urandom & 32'h0000_0FFC;
      if ($urandom_range(0, 3) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
      bus.trap_valid = trap; bus.redirect_valid = redir; bus.redirect_pc = tgt;
      bus.instr_ready = ($urandom_range(0, 9) < 6);
      if (!bus.halt && $urandom_range(0, 39) == 0) bus.halt = 1'b1;
      else if (bus.halt && $urandom_range(0, 4) == 0) bus.halt = 1'b0;
      bus.imem_ack = 1'b0;
      if (bus.imem_req) begin
        if (lat == 0) begin
          bus.imem_ack = 1'b1; bus.imem_rdata = mem_word(bus.imem_addr); lat = $urandom_range(0, 3);
        end else begin
          lat--;
        end
      end
      exp_mis = 1'b0;
      if (trap) begin
        exp_pc = 32'h100;
      end else if (redir) begin
        exp_pc = {tgt[31:2], 2'b00};
`ifdef PC_MISALIGN_TRAP_EN
        if (tgt[1:0] != 2'b00) begin exp_pc = 32'h100; exp_mis = 1'b1; end
`endif
      end else if (bus.instr_valid && bus.instr_ready) begin
        exp_pc += 32'd4; delivered++;
      end
      tick();
    end
    idle_inputs();
    checks++; if (delivered < 50) begin errors++; $display("FAIL rnd_progress: delivered %0d want >= 50", delivered); end
  endtask

  initial begin
    checks = 0; errors = 0;
    salt = $urandom;
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_sequential();
    test_stall();
    test_discard();
    test_trap_priority();
    test_halt();
    test_misalign();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
